// File: rtl/ldr_pkg.sv
`default_nettype none
//============================================================================
// Module   : ldr_pkg
// Desc     : Shared types and constants for the light-sensor sample
//            controller (FSM state encoding, ADC width, default timing).
// Revision : 1.0 - initial release
//============================================================================
package ldr_pkg;

    localparam int ADC_W               = 10;
    localparam int DEFAULT_SAMPLE_DIV  = 100000;
    localparam int DEFAULT_TIMEOUT_CYC = 1024;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        DECIDE = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/ldr_tick_gen.sv
`default_nettype none
//============================================================================
// Module   : ldr_tick_gen
// Desc     : Divider counting 0..DIV-1 while enabled; emits a one-cycle
//            tick on the terminal count. Synchronous clear holds it at 0.
// Revision : 1.0 - initial release
//============================================================================
module ldr_tick_gen #(
    parameter int DIV = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int            CW     = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] c_last = CW'(DIV - 1);

    logic [CW-1:0] r_cnt;

    // Free-running divider, wraps at the terminal count, parked at 0 on clear
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= (r_cnt == c_last) ? '0 : r_cnt + 1'b1;
        end
    end

    assign tick = en && !clr && (r_cnt == c_last);

endmodule
`default_nettype wire

// File: rtl/ldr_sample_ctrl.sv
`default_nettype none
//============================================================================
// Module   : ldr_sample_ctrl
// Desc     : Periodic ADC sampling over req/ack, averaging of 2^AVG_LOG2
//            samples and hysteresis-driven dark indicator LED.
// Config   : define LDR_BLINK_EN to blink the LED (BLINK_DIV half-period)
//            while dark instead of holding it steady.
// Revision : 1.0 - initial release
//============================================================================
module ldr_sample_ctrl
    import ldr_pkg::*;
#(
    parameter int SAMPLE_DIV  = DEFAULT_SAMPLE_DIV,
    parameter int AVG_LOG2    = 2,
    parameter int TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC,
    parameter int BLINK_DIV   = 25000000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    output logic             adc_req,
    input  logic             adc_ack,
    input  logic [ADC_W-1:0] adc_data,
    input  logic [ADC_W-1:0] thresh_on,
    input  logic [ADC_W-1:0] thresh_off,
    output logic             led,
    output logic [ADC_W-1:0] avg_value,
    output logic             avg_valid,
    output logic             timeout_err
);

    localparam int            ACC_W      = ADC_W + AVG_LOG2;
    localparam int            CNT_W      = AVG_LOG2 + 1;
    localparam int            TO_W       = $clog2(TIMEOUT_CYC) + 1;
    localparam logic [CNT_W-1:0] c_last_cnt = CNT_W'((1 << AVG_LOG2) - 1);
    localparam logic [TO_W-1:0]  c_to_last  = TO_W'(TIMEOUT_CYC - 1);

    // Reject configurations the counters are not sized for
    if (SAMPLE_DIV < 2 || BLINK_DIV < 2 || AVG_LOG2 < 0 || AVG_LOG2 > 6 ||
        TIMEOUT_CYC < 1) begin : g_cfg_check
        $error("ldr_sample_ctrl: unsupported parameter combination");
    end

    state_t             r_state;
    state_t             w_state_next;
    logic               w_tick;
    logic               w_acc_add;
    logic               w_acc_clr;
    logic               w_to_clr;
    logic               w_to_set;
    logic               w_decide;
    logic [ACC_W-1:0]   r_acc;
    logic [CNT_W-1:0]   r_cnt;
    logic [TO_W-1:0]    r_to_cnt;
    logic               r_upd;
    logic [ADC_W-1:0]   r_avg_pend;
    logic               r_dark;

    ldr_tick_gen #(.DIV(SAMPLE_DIV)) u_sample_tick (
        .clk   (clk),
        .reset (reset),
        .en    (enable),
        .clr   (!enable),
        .tick  (w_tick)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_next;
    end

    // Next-state and datapath control; a low enable aborts everything
    always_comb begin
        w_state_next = r_state;
        w_acc_add    = 1'b0;
        w_acc_clr    = 1'b0;
        w_to_clr     = 1'b1;
        w_to_set     = 1'b0;
        w_decide     = 1'b0;
        if (!enable) begin
            w_state_next = IDLE;
            w_acc_clr    = 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_tick) w_state_next = REQ;
                end
                REQ: begin
                    if (adc_ack) begin
                        w_acc_add    = 1'b1;
                        w_state_next = (r_cnt == c_last_cnt) ? DECIDE : IDLE;
                    end else if (r_to_cnt == c_to_last) begin
                        w_to_set     = 1'b1;
                        w_state_next = IDLE;
                    end else begin
                        w_to_clr     = 1'b0;
                    end
                end
                DECIDE: begin
                    w_decide     = 1'b1;
                    w_acc_clr    = 1'b1;
                    w_state_next = IDLE;
                end
                default: w_state_next = IDLE;
            endcase
        end
    end

    assign adc_req = (r_state == REQ);

    // Sample accumulator and count of samples in the current set
    always_ff @(posedge clk) begin
        if (reset || w_acc_clr) begin
            r_acc <= '0;
            r_cnt <= '0;
        end else if (w_acc_add) begin
            r_acc <= r_acc + ACC_W'(adc_data);
            if (r_cnt != c_last_cnt) r_cnt <= r_cnt + 1'b1;
        end
    end

    // Ack-wait counter and sticky timeout flag
    always_ff @(posedge clk) begin
        if (reset) begin
            r_to_cnt    <= '0;
            timeout_err <= 1'b0;
        end else begin
            r_to_cnt <= w_to_clr ? '0 : r_to_cnt + 1'b1;
            if (w_to_set) timeout_err <= 1'b1;
        end
    end

    // Capture the truncated mean in the DECIDE cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            r_upd      <= 1'b0;
            r_avg_pend <= '0;
        end else begin
            r_upd      <= w_decide;
            r_avg_pend <= r_acc[AVG_LOG2 +: ADC_W];
        end
    end

    // Publish the average and apply hysteresis (dark takes priority)
    always_ff @(posedge clk) begin
        if (reset) begin
            avg_value <= '0;
            avg_valid <= 1'b0;
            r_dark    <= 1'b0;
        end else begin
            avg_valid <= 1'b0;
            if (r_upd && enable) begin
                avg_value <= r_avg_pend;
                avg_valid <= 1'b1;
                if (r_avg_pend <= thresh_on)       r_dark <= 1'b1;
                else if (r_avg_pend >= thresh_off) r_dark <= 1'b0;
            end
        end
    end

`ifdef LDR_BLINK_EN
    logic w_blink_tick;
    logic r_blink;

    ldr_tick_gen #(.DIV(BLINK_DIV)) u_blink_tick (
        .clk   (clk),
        .reset (reset),
        .en    (r_dark),
        .clr   (!r_dark),
        .tick  (w_blink_tick)
    );

    // Blink phase starts lit on entering dark and toggles each half-period
    always_ff @(posedge clk) begin
        if (reset || !r_dark) r_blink <= 1'b1;
        else if (w_blink_tick) r_blink <= ~r_blink;
    end

    assign led = r_dark & r_blink;
`else
    assign led = r_dark;
`endif

endmodule
`default_nettype wire
